// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider with a start/busy/valid handshake.
//   Restoring radix-2 mantissa division (one quotient bit per cycle), full
//   special-case decoding, subnormal flush-to-zero, exception flags.
//   Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise
//   the quotient is truncated (round toward zero). Latency and flags are the
//   same in both builds.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   start       request, sampled only while idle
//   a, b        dividend / divisor, {sign, exp[EXP_W], frac[MAN_W]}
//   busy        normal-path division in progress
//   valid       one-cycle pulse, result/flags updated in that cycle
//   result      quotient, held until the next valid
//   flags       {invalid, div_by_zero, overflow, underflow}, held with result
module fp_div_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   valid,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int unsigned W         = 1 + EXP_W + MAN_W;
    localparam int unsigned EW        = EXP_W + 2;        // signed working exponent
    localparam int unsigned MW        = MAN_W + 1;        // mantissa with hidden bit
    localparam int unsigned RW        = MAN_W + 2;        // partial remainder
    localparam int unsigned QW        = MAN_W + 3;        // quotient bits
    localparam int unsigned CNT_W     = $clog2(MAN_W + 4);
    localparam int unsigned BIAS      = 2**(EXP_W-1) - 1;
    localparam int unsigned EXP_MAX   = 2**EXP_W - 1;
    localparam int unsigned ITER_LAST = MAN_W + 2;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_DIV_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [QW-1:0]        quot, quot_nxt;
    logic [RW-1:0]        rem, rem_nxt;
    logic [MW-1:0]        mb, mb_nxt;
    logic signed [EW-1:0] exp_r, exp_nxt;
    logic                 sign_r, sign_nxt;
    logic [W-1:0]         pend_res, pend_res_nxt;
    logic [3:0]           pend_flg, pend_flg_nxt;
    logic                 busy_nxt, valid_nxt;
    logic [W-1:0]         result_nxt;
    logic [3:0]           flags_nxt;

    // Operand decode; exponent 0 means zero (subnormals flushed)
    logic [EXP_W-1:0] ea_c, eb_c;
    logic [MAN_W-1:0] fa_c, fb_c;
    logic             a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
    logic             sign_c;

    assign ea_c     = a[MAN_W +: EXP_W];
    assign eb_c     = b[MAN_W +: EXP_W];
    assign fa_c     = a[MAN_W-1:0];
    assign fb_c     = b[MAN_W-1:0];
    assign a_zero_c = (ea_c == '0);
    assign b_zero_c = (eb_c == '0);
    assign a_inf_c  = (ea_c == {EXP_W{1'b1}}) && (fa_c == '0);
    assign b_inf_c  = (eb_c == {EXP_W{1'b1}}) && (fb_c == '0);
    assign a_nan_c  = (ea_c == {EXP_W{1'b1}}) && (fa_c != '0);
    assign b_nan_c  = (eb_c == {EXP_W{1'b1}}) && (fb_c != '0);
    assign sign_c   = a[W-1] ^ b[W-1];

    // Special-case resolution, order matters (NaN-producing cases first)
    logic         special_c;
    logic [W-1:0] spec_res_c;
    logic [3:0]   spec_flg_c;

    always_comb begin
        special_c  = 1'b1;
        spec_res_c = '0;
        spec_flg_c = '0;
        if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
            spec_res_c = QNAN;
            spec_flg_c = 4'b1000;
        end else if (b_zero_c && !a_inf_c) begin
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flg_c = 4'b0100;
        end else if (a_inf_c) begin
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_c || a_zero_c) begin
            spec_res_c = {sign_c, {(W-1){1'b0}}};
        end else begin
            special_c = 1'b0;
        end
    end

    // Capture: the integer quotient bit is resolved here, ITER supplies the rest
    logic [MW-1:0]        ma_c, mb_c, r0_c;
    logic                 q0_c;
    logic signed [EW-1:0] e_c;

    assign ma_c = {1'b1, fa_c};
    assign mb_c = {1'b1, fb_c};
    assign q0_c = (ma_c >= mb_c);
    assign r0_c = q0_c ? (ma_c - mb_c) : ma_c;
    assign e_c  = EW'(ea_c) - EW'(eb_c) + EW'(BIAS);

    // One restoring step; remainder stays below 2*mb so RW bits suffice
    logic          ge_c;
    logic [RW-1:0] diff_c, sub_c;

    assign ge_c   = (rem >= {1'b0, mb});
    assign diff_c = rem - {1'b0, mb};
    assign sub_c  = ge_c ? diff_c : rem;

    // Normalise, round, range-check
    logic [MW-1:0]        mant_c;
    logic                 g_c, s_c, inc_c, carry_c;
    logic [MW:0]          sum_c;
    logic [MAN_W-1:0]     frac_c;
    logic signed [EW-1:0] e_n_c, e_r_c;
    logic [W-1:0]         rnd_res_c;
    logic [3:0]           rnd_flg_c;

    always_comb begin
        if (quot[QW-1]) begin
            mant_c = quot[QW-1:2];
            g_c    = quot[1];
            s_c    = quot[0] | (|rem);
            e_n_c  = exp_r;
        end else begin
            mant_c = quot[QW-2:1];
            g_c    = quot[0];
            s_c    = |rem;
            e_n_c  = exp_r - EW'(1);
        end
        inc_c   = RNE & g_c & (s_c | mant_c[0]);
        sum_c   = {1'b0, mant_c} + (MW+1)'(inc_c);
        carry_c = sum_c[MW];
        frac_c  = carry_c ? sum_c[MW-1:1] : sum_c[MAN_W-1:0];
        e_r_c   = e_n_c + EW'(carry_c);
        if (e_r_c >= $signed(EW'(EXP_MAX))) begin
            rnd_res_c = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flg_c = 4'b0010;
        end else if (e_r_c <= $signed(EW'(0))) begin
            rnd_res_c = {sign_r, {(W-1){1'b0}}};
            rnd_flg_c = 4'b0001;
        end else begin
            rnd_res_c = {sign_r, e_r_c[EXP_W-1:0], frac_c};
            rnd_flg_c = 4'b0000;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special_c ? DONE : ITER;
            ITER:    if (cnt == CNT_W'(ITER_LAST)) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        busy_nxt     = busy;
        valid_nxt    = 1'b0;
        result_nxt   = result;
        flags_nxt    = flags;
        cnt_nxt      = cnt;
        quot_nxt     = quot;
        rem_nxt      = rem;
        mb_nxt       = mb;
        exp_nxt      = exp_r;
        sign_nxt     = sign_r;
        pend_res_nxt = pend_res;
        pend_flg_nxt = pend_flg;
        case (state)
            IDLE: begin
                busy_nxt = start && !special_c;
                if (start) begin
                    if (special_c) begin
                        pend_res_nxt = spec_res_c;
                        pend_flg_nxt = spec_flg_c;
                    end else begin
                        cnt_nxt  = CNT_W'(1);
                        quot_nxt = QW'(q0_c);
                        rem_nxt  = {r0_c, 1'b0};
                        mb_nxt   = mb_c;
                        exp_nxt  = e_c;
                        sign_nxt = sign_c;
                    end
                end
            end
            ITER: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt + CNT_W'(1);
                quot_nxt = {quot[QW-2:0], ge_c};
                rem_nxt  = {sub_c[RW-2:0], 1'b0};
            end
            ROUND: begin
                busy_nxt     = 1'b1;
                pend_res_nxt = rnd_res_c;
                pend_flg_nxt = rnd_flg_c;
            end
            DONE: begin
                busy_nxt   = 1'b0;
                valid_nxt  = 1'b1;
                result_nxt = pend_res;
                flags_nxt  = pend_flg;
                cnt_nxt    = '0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            mb       <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            pend_res <= '0;
            pend_flg <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else begin
            cnt      <= cnt_nxt;
            quot     <= quot_nxt;
            rem      <= rem_nxt;
            mb       <= mb_nxt;
            exp_r    <= exp_nxt;
            sign_r   <= sign_nxt;
            pend_res <= pend_res_nxt;
            pend_flg <= pend_flg_nxt;
            busy     <= busy_nxt;
            valid    <= valid_nxt;
            result   <= result_nxt;
            flags    <= flags_nxt;
        end
    end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised iterative IEEE-754 floating-point divider: restoring radix-2 mantissa division, full special-case decoding, exception flags and optional round-to-nearest-even. It is the configurable-width successor of the single-precision divider in the FP arithmetic library, and any datapath that needs a divide uses it through a start/busy/valid handshake. Defaults give binary32. Other EXP_W/MAN_W settings give bfloat16, binary16 or custom formats.

## Interface
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; W = 1+EXP_W+MAN_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  W  dividend, {sign, exp, frac}
- b  in  W  divisor
- busy  out  1  normal-path division in progress
- valid  out  1  one-cycle pulse; result/flags updated this cycle
- result  out  W  quotient, held until next valid
- flags  out  4  {invalid, div_by_zero, overflow, underflow}, held with result

## Operation
- States: IDLE, ITER, ROUND, DONE.
- IDLE with start=1: captures and unpacks a, b. Operands may change afterwards.
- Subnormal inputs are flushed to zero; the sign is kept.
- Sign = a.sign ^ b.sign for every result except NaN.
- Special cases resolve in IDLE and go straight to DONE:
  - NaN operand, 0/0 or inf/inf → qNaN {0, all-ones, 1'b1, zeros}, invalid.
  - finite-nonzero/0 → signed inf, div_by_zero.
  - inf/finite → signed inf.
  - finite/inf → signed zero.
  - 0/finite-nonzero → signed zero.
- Normal path:
  - Mantissas are {1, frac}. Exponent e = ea − eb + BIAS, signed, EXP_W+2 bits.
  - ITER runs MAN_W+3 restoring iterations: one quotient bit per cycle, MSB first (integer bit, then fraction bits).
  - ROUND: if the integer bit is 0, shift left by 1 and decrement e.
  - Keep MAN_W fraction bits plus guard G. Sticky S = OR(remaining quotient bits, remainder ≠ 0).
  - Rounding per Configuration. A mantissa carry-out shifts right and increments e.
  - e ≥ 2^EXP_W−1 → signed inf, overflow.
  - e ≤ 0 → signed zero, underflow (no subnormal outputs).
- DONE: register result/flags, pulse valid, return to IDLE.

## Timing
- Reset values: busy=0, valid=0, result=0, flags=0, state IDLE, iteration counter 0.
- Normal path, with start sampled at edge T:
  - busy=1 from T+1 through T+MAN_W+4.
  - valid=1 and busy=0 in cycle T+MAN_W+5 (28 cycles for binary32).
  - Latency is fixed and independent of operand values and rounding mode.
- Special cases: valid=1 in cycle T+2; busy stays 0.
- start while busy is ignored. No queuing.
- start in the valid cycle is accepted, because the FSM is already IDLE. Back-to-back throughput is one result per MAN_W+5 cycles.
- start held high continuously: a new operation launches each time the FSM reaches IDLE.
- rst mid-operation: immediate abort to reset values. No valid is produced for the aborted operation.
- Iteration counter width = clog2(MAN_W+4). The counter does not wrap within an operation.

## Configuration
- FP_DIV_RNE_EN defined: round to nearest, ties to even. Increment if G & (S | lsb).
- Undefined: round toward zero (truncate). G and S are computed but ignored.
- In both builds, flags and latency are identical.

## Test plan
- 0x40C00000 / 0x40000000 (6/2): valid at T+28, result 0x40400000, flags 0, busy high T+1..T+27.
- 0x3F800000 / 0x40400000 (1/3): 0x3EAAAAAB with FP_DIV_RNE_EN, 0x3EAAAAAA without.
- 0xBFC00000 / 0x3F000000: 0xC0400000. Also 0x00800000 / 0x40000000 → 0x00000000, flags 4'b0001.
- 0x3F800000 / 0x00000000 → 0x7F800000, flags 4'b0100, valid at T+2, busy never set. 0/0 → 0x7FC00000, flags 4'b1000.
- 0x7F000000 / 0x3E800000 → 0x7F800000, flags 4'b0010. Also 0x7F800000 / 0x7F800000 → 0x7FC00000, invalid.
- start at T, second start at T+5 (ignored), rst at T+10: all outputs 0 immediately. New start 6/2 after reset → 0x40400000 exactly 28 cycles later.
- Parameter sweep EXP_W=8, MAN_W=7 (bfloat16): 0x40C0 / 0x4000 → 0x4040, valid at T+12.
